// File: rtl/change_dispense_ctrl.sv
// ---------------------------------------------------------------------------
// change_dispense_ctrl
//
// Coin-change sequencer for the ticket machine dispenser. Takes a change
// amount, then requests one coin at a time (largest denomination that fits
// and is in stock), waiting for a per-coin acknowledge. Keeps per-tube
// stock counts and reports an error when change cannot be completed.
//
// Optional build macro: ACK_TIMEOUT_EN
//   defined   : an ack watchdog in ISSUE declares a jam after ACK_TIMEOUT
//               cycles without coin_ack (goes to ERR, nothing deducted).
//   undefined : ISSUE waits for coin_ack indefinitely, no watchdog logic.
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   asynchronous reset, active low
//   start       in   pulse: begin dispensing `amount`
//   amount      in   [7:0] change value (yuan), sampled on start
//   abort       in   pulse: cancel the running transaction
//   stock_load  in   pulse: load all stock counters from stock_val
//   stock_val   in   [4*STOCK_W-1:0] {n50,n10,n5,n1}, n1 in LSBs
//   coin_ack    in   dispenser ejected the requested coin
//   qian50/10/5/1 out coin request lines, registered, at most one high
//   busy        out  transaction in progress (not IDLE/ERR)
//   done        out  one-cycle pulse on full delivery
//   err         out  error (stock exhausted or jam), held until start/abort
//   remaining   out  [7:0] undelivered change value
//   stock       out  [4*STOCK_W-1:0] stock counters, same packing as stock_val
// ---------------------------------------------------------------------------
module change_dispense_ctrl #(
   parameter int STOCK_W     = 6,
   parameter int ACK_TIMEOUT = 15
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [7:0]             amount,
   input  logic                   abort,
   input  logic                   stock_load,
   input  logic [4*STOCK_W-1:0]   stock_val,
   input  logic                   coin_ack,
   output logic                   qian50,
   output logic                   qian10,
   output logic                   qian5,
   output logic                   qian1,
   output logic                   busy,
   output logic                   done,
   output logic                   err,
   output logic [7:0]             remaining,
   output logic [4*STOCK_W-1:0]   stock
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SELECT,
      S_ISSUE,
      S_GAP,
      S_DONE,
      S_ERR
   } state_t;

   state_t                     r_state;
   state_t                     w_next;

   // Tube index 0..3 = 1, 5, 10, 50 yuan; matches the stock_val packing.
   logic [3:0][STOCK_W-1:0]    r_stock;
   logic [7:0]                 r_rem;
   logic [1:0]                 r_sel;
   logic [3:0]                 r_qian;
   logic                       r_busy;
   logic                       r_done;
   logic                       r_err;

   logic [1:0]                 w_sel;
   logic                       w_sel_ok;
   logic [1:0]                 w_issue_idx;
   logic [3:0]                 w_qian_nx;
   logic                       w_accept;
   logic                       w_ack_take;
   logic                       w_load_take;

   function automatic logic [7:0] den(input logic [1:0] idx);
      case (idx)
         2'd0:    den = 8'd1;
         2'd1:    den = 8'd5;
         2'd2:    den = 8'd10;
         default: den = 8'd50;
      endcase
   endfunction

   // start/stock_load are only honoured when no transaction is running.
   assign w_accept    = (r_state == S_IDLE) || (r_state == S_ERR);
   assign w_load_take = stock_load && w_accept;
   // An ack in ISSUE always counts, even alongside abort.
   assign w_ack_take  = (r_state == S_ISSUE) && coin_ack;

   // Largest denomination that fits the remainder and has a coin in its tube.
   always_comb begin
      w_sel    = 2'd0;
      w_sel_ok = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if ((den(2'(i)) <= r_rem) && (r_stock[i] != '0)) begin
            w_sel    = 2'(i);
            w_sel_ok = 1'b1;
         end
      end
   end

`ifdef ACK_TIMEOUT_EN
   localparam int TW = $clog2(ACK_TIMEOUT + 1);
   logic [TW-1:0] r_tmo;
   logic          w_tmo_hit;

   // Hit on the cycle whose missing ack would bring the count to ACK_TIMEOUT,
   // so the request line is high for exactly ACK_TIMEOUT cycles.
   assign w_tmo_hit = (r_state == S_ISSUE) && !coin_ack &&
                      (r_tmo == TW'(ACK_TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_tmo <= '0;
      end else if (r_state != S_ISSUE) begin
         r_tmo <= '0;
      end else if (!coin_ack) begin
         r_tmo <= r_tmo + TW'(1);
      end
   end
`endif

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) w_next = (amount == 8'd0) ? S_DONE : S_SELECT;
         end
         S_SELECT: begin
            if (abort)               w_next = S_IDLE;
            else if (r_rem == 8'd0)  w_next = S_DONE;
            else if (w_sel_ok)       w_next = S_ISSUE;
            else                     w_next = S_ERR;
         end
         S_ISSUE: begin
            if (abort)               w_next = S_IDLE;
            else if (coin_ack)       w_next = S_GAP;
`ifdef ACK_TIMEOUT_EN
            else if (w_tmo_hit)      w_next = S_ERR;
`endif
         end
         S_GAP: begin
            w_next = abort ? S_IDLE : S_SELECT;
         end
         S_DONE: begin
            w_next = S_IDLE;
         end
         S_ERR: begin
            if (start)               w_next = (amount == 8'd0) ? S_DONE : S_SELECT;
            else if (abort)          w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Request line for the coming cycle: newly chosen tube when entering
   // ISSUE from SELECT, otherwise the latched choice while still waiting.
   always_comb begin
      w_issue_idx = (r_state == S_SELECT) ? w_sel : r_sel;
      w_qian_nx   = 4'b0000;
      if (w_next == S_ISSUE) w_qian_nx[w_issue_idx] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_sel   <= 2'd0;
         r_qian  <= 4'b0000;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         if ((r_state == S_SELECT) && (w_next == S_ISSUE)) r_sel <= w_sel;
         r_qian  <= w_qian_nx;
         r_busy  <= (w_next != S_IDLE) && (w_next != S_ERR);
         r_done  <= (w_next == S_DONE);
         // err is held for as long as ERR is occupied; start/abort leave it.
         r_err   <= (w_next == S_ERR);
      end
   end

   // Remaining change value
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rem <= 8'd0;
      end else if (start && w_accept) begin
         r_rem <= amount;
      end else if (w_ack_take) begin
         r_rem <= r_rem - den(r_sel);
      end
   end

   // Stock counters; a load and a deduction can never coincide because
   // loads are refused while busy.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stock <= '0;
      end else if (w_load_take) begin
         r_stock <= stock_val;
      end else if (w_ack_take) begin
         r_stock[r_sel] <= r_stock[r_sel] - STOCK_W'(1);
      end
   end

   assign qian1     = r_qian[0];
   assign qian5     = r_qian[1];
   assign qian10    = r_qian[2];
   assign qian50    = r_qian[3];
   assign busy      = r_busy;
   assign done      = r_done;
   assign err       = r_err;
   assign remaining = r_rem;
   assign stock     = r_stock;

endmodule

// File: doc/change_dispense_ctrl.md
Name: change_dispense_ctrl

Overview:
- Sequencer for the ticket machine's coin-change dispenser.
- Accepts a change amount from the sale/payment logic and issues one coin request at a time on the qian50/qian10/qian5/qian1 lines, largest denomination first, with a per-coin acknowledge handshake.
- Tracks per-denomination coin stock and falls back to smaller coins when a tube is empty.
- Flags an error when change cannot be completed.

Parameters:
- STOCK_W, 6, width of each per-denomination stock counter (max 63 coins per tube).
- ACK_TIMEOUT, 15, cycles to wait for coin_ack before declaring a jam (used only with ACK_TIMEOUT_EN).

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begin dispensing `amount`.
- amount  input  8  change value in yuan, 0..255, sampled on start.
- abort  input  1  one-cycle pulse; cancel current transaction.
- stock_load  input  1  one-cycle pulse; load all stock counters.
- stock_val  input  4*STOCK_W  packed stock {n50,n10,n5,n1}, n1 in LSBs.
- coin_ack  input  1  dispenser confirms the requested coin was ejected.
- qian50, qian10, qian5, qian1  output  1 each  coin request lines; at most one high.
- busy  output  1  high in any state other than IDLE/ERR.
- done  output  1  one-cycle pulse when change is fully delivered.
- err  output  1  sticky error (stock exhausted or jam).
- remaining  output  8  undelivered change value.
- stock  output  4*STOCK_W  current stock counters, same packing as stock_val.

Behaviour:
- Reset (rst low, async):
  - State IDLE.
  - All qian lines, busy, done, err = 0.
  - remaining = 0; stock = 0; timeout counter = 0.
- States: IDLE, SELECT, ISSUE, GAP, DONE, ERR.
- IDLE:
  - stock_load: stock <= stock_val on that edge.
  - start with amount!=0: remaining <= amount, err <= 0, go SELECT.
  - start with amount==0: go DONE.
  - stock_load and start in the same cycle: both accepted; SELECT sees the new stock.
- SELECT:
  - remaining==0: go DONE.
  - Otherwise choose the largest d in {50,10,5,1} with d<=remaining and stock_d>0, latch the choice, go ISSUE.
  - No such d: go ERR.
- ISSUE:
  - Only the chosen qian line is high, registered, held every cycle until ack.
  - On a cycle with coin_ack=1: remaining -= d, stock_d -= 1, go GAP.
  - coin_ack in any state other than ISSUE is ignored.
- GAP: all qian low for exactly one cycle, then SELECT.
- DONE: done=1 for one cycle, then IDLE.
- ERR:
  - err=1, busy=0, qian all low; remaining holds the undelivered value.
  - start leaves ERR and behaves as start from IDLE, clearing err.
  - abort from ERR: go IDLE, clear err.
  - stock_load is accepted in ERR.
- Latency:
  - start at edge N → SELECT at N+1 → first qian high after edge N+2.
  - With immediate ack, each coin costs 3 cycles (SELECT, ISSUE, GAP).
- Ignored inputs:
  - start while busy is ignored.
  - stock_load while busy is ignored.
- abort:
  - From SELECT/ISSUE/GAP: go IDLE next edge, qian lines drop.
  - Coins already acked stay deducted; remaining keeps the undelivered value; no done pulse.
  - abort and coin_ack in the same ISSUE cycle: the ack is counted (deduct coin), then go IDLE.
- Stock counters never underflow; a tube is only selected when its count is >0.
- remaining never underflows; d<=remaining is guaranteed at selection.

Optional Feature:
- ACK_TIMEOUT_EN defined:
  - In ISSUE a counter increments each cycle without coin_ack.
  - Reaching ACK_TIMEOUT goes to ERR (jam); qian drops; no stock or remaining deduction.
  - Counter clears on entering ISSUE.
- ACK_TIMEOUT_EN undefined: ISSUE waits indefinitely; no counter is synthesized.

Test Plan:
1. Load stock {5,5,5,5}; start amount=117; coin_ack tied high.
   - Response: pulses qian50,qian50,qian10,qian5,qian1,qian1 each 3 cycles apart, then done.
   - Final state: remaining=0, stock {3,4,4,3}.
2. Load {0,20,5,5}; start amount=117.
   - Response: 11×qian10, 1×qian5, 2×qian1, then done.
   - Final state: stock {0,9,4,3}.
3. Load {1,1,1,1}; start amount=100.
   - Response: qian50, qian10, qian5, qian1 in order, then err=1, busy=0.
   - Final state: remaining=34.
4. ACK_TIMEOUT_EN build; stock {5,5,5,5}; start amount=117; coin_ack held low.
   - Response: qian50 high for 15 cycles, then low; err=1.
   - Final state: remaining=117, stock unchanged.
5. amount=117, stock {5,5,5,5}, abort asserted during the second qian50 ISSUE without ack.
   - Response: IDLE next edge, no done pulse.
   - Final state: remaining=67, stock50=4.
   - Then assert rst low mid-ISSUE: all outputs and stock go to 0 asynchronously.
6. start amount=0 → done one cycle after start, no qian line ever high; start pulsed while busy → ignored, sequence unaffected.
